// File: rtl/sub_result_stage_pkg.sv
// Shared constants and types for the subtractor result stage.
package sub_result_stage_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned FLAG_W = 4;

    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef struct packed {
        logic [DATA_W-1:0] diff;
        logic [FLAG_W-1:0] flags;
    } entry_t;

endpackage

// File: rtl/sub_flags_4b.sv
// Combinational {V,C,N,Z} flag generation for a 4-bit subtraction x - y.
module sub_flags_4b
    import sub_result_stage_pkg::*;
(
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    input  logic [DATA_W-1:0] i_diff,
    output logic [FLAG_W-1:0] o_flags
);

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_Z] = (i_diff == '0);
        o_flags[FLAG_N] = i_diff[DATA_W-1];
        // Borrow out of the MSB is the unsigned less-than
        o_flags[FLAG_C] = (i_x < i_y);
        o_flags[FLAG_V] = (i_x[DATA_W-1] != i_y[DATA_W-1]) &&
                          (i_diff[DATA_W-1] != i_x[DATA_W-1]);
    end

endmodule

// File: rtl/sub_result_stage.sv
// Valid/ready FIFO buffering subtractor results with their flags.
// Optional sticky overflow flag enabled by macro SUB_STAGE_STICKY_EN.
module sub_result_stage
    import sub_result_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_x,
    input  logic [DATA_W-1:0]        in_y,
    input  logic [DATA_W-1:0]        in_diff,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_diff,
    output logic [FLAG_W-1:0]        out_flags,
`ifdef SUB_STAGE_STICKY_EN
    input  logic                     clr_sticky,
    output logic                     sticky_v,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [FLAG_W-1:0] w_flags;
    logic              w_push;
    logic              w_pop;
    entry_t            w_head;

    sub_flags_4b u_flags (
        .i_x     (in_x),
        .i_y     (in_y),
        .i_diff  (in_diff),
        .o_flags (w_flags)
    );

    assign in_ready  = (r_count < DEPTH_C);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign out_diff  = out_valid ? w_head.diff  : '0;
    assign out_flags = out_valid ? w_head.flags : '0;
    assign count     = r_count;

    // Storage carries no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= '{diff: in_diff, flags: w_flags};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SUB_STAGE_STICKY_EN
    logic r_sticky_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky_v <= 1'b0;
        end else if (w_push && w_flags[FLAG_V]) begin
            r_sticky_v <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky_v <= 1'b0;
        end
    end

    assign sticky_v = r_sticky_v;
`endif

endmodule

// File: doc/sub_result_stage.md
SUB_RESULT_STAGE -- requirements
Module: sub_result_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of result-buffer entries (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register SHALL update on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream 4-bit subtractor result is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the stage can accept a result.
REQ-006 The block SHALL have ports in_x and in_y, input, 4 bits each: the subtractor minuend and subtrahend.
REQ-007 The block SHALL have port in_diff, input, 4 bits: the subtractor output, x minus y modulo 16.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the buffer head is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head.
REQ-010 The block SHALL have port out_diff, output, 4 bits: the buffered difference.
REQ-011 The block SHALL have port out_flags, output, 4 bits, ordered {V,C,N,Z}.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 The block SHALL have port clr_sticky, input, 1 bit, present only under SUB_STAGE_STICKY_EN.
REQ-014 The block SHALL have port sticky_v, output, 1 bit, present only under SUB_STAGE_STICKY_EN.

Function
REQ-015 Flags SHALL be computed combinationally from the inputs at push time and stored with the difference.
- Z = (in_diff == 0).
- N = in_diff[3].
- C (borrow) = unsigned in_x < in_y.
- V = (in_x[3] != in_y[3]) and (in_diff[3] != in_x[3]).
REQ-016 in_ready SHALL equal (count < DEPTH); it SHALL NOT depend on out_ready.
REQ-017 A push SHALL occur on a rising edge when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-018 out_valid SHALL equal (count != 0); out_diff and out_flags SHALL show the head entry and SHALL be held stable while out_valid=1 and out_ready=0.
REQ-019 Latency: an entry pushed into an empty buffer at edge N SHALL appear on out_* immediately after edge N.
REQ-020 Push and pop on the same edge SHALL leave count unchanged and SHALL preserve FIFO order, including when count is 1.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 A push attempted while full SHALL be ignored; a pop requested while empty SHALL be ignored; count SHALL never exceed DEPTH or drop below 0.
REQ-023 When out_valid=0, out_diff and out_flags SHALL read 0.

Reset
REQ-024 While rst=1 at an edge, count, the pointers, out_valid, out_diff, out_flags and sticky_v SHALL become 0, and in_ready SHALL become 1.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries, and a push presented in the same cycle SHALL be dropped.

Configuration
REQ-026 Macro SUB_STAGE_STICKY_EN defined: sticky_v SHALL set on any push with V=1 and SHALL clear on clr_sticky=1; if both occur in the same cycle, set SHALL win.
REQ-027 Macro SUB_STAGE_STICKY_EN undefined: the clr_sticky and sticky_v ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the flag bit-index constants (FLAG_V=3, FLAG_C=2, FLAG_N=1, FLAG_Z=0) and the 4-bit data width constant.
REQ-029 Flag generation SHALL be a combinational sub-module named sub_flags_4b; the buffer and handshake logic SHALL reside in sub_result_stage.

Verification
REQ-030 x=1000, y=1001, diff=1111 pushed into empty -> the next cycle shows out_diff=1111 and out_flags=0110.
REQ-031 x=1101, y=0110, diff=0111 -> out_flags=1000; with SUB_STAGE_STICKY_EN, sticky_v=1 until clr_sticky is pulsed.
REQ-032 x=0110, y=0110, diff=0000 -> out_flags=0001.
REQ-033 DEPTH=2, out_ready=0, three consecutive pushes -> in_ready=0 after the second push, the third push is dropped, count=2, and order is preserved on drain.
REQ-034 count=1 with simultaneous push and pop every cycle for 8 cycles -> count stays 1 and the outputs follow the inputs with 1-cycle delay.
REQ-035 rst=1 with count=2 -> the following cycle shows count=0, out_valid=0, in_ready=1 and out_flags=0000.
